// File: rtl/csr_access_arbiter.sv
// Arbitrates the EX-stage CSR port between pipeline CSR instructions and a host debug port.
// The pipeline has priority. A bounded starvation counter forces one stall cycle so a waiting host access completes.
module csr_access_arbiter #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 12,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_csr_we,
  input  logic              pipe_csr_rd,
  input  logic [AWIDTH-1:0] pipe_addr,
  input  logic [2:0]        pipe_func,
  input  logic [DWIDTH-1:0] pipe_wdata,
  output logic              pipe_stall,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_addr,
  input  logic [DWIDTH-1:0] host_wdata,
  output logic              host_resp_valid,
  input  logic              host_resp_ready,
  output logic [DWIDTH-1:0] host_resp_data,
  output logic              csr_we,
  output logic              csr_rd,
  output logic [AWIDTH-1:0] csr_addr,
  output logic [2:0]        csr_func,
  output logic [DWIDTH-1:0] csr_data_in,
  input  logic [DWIDTH-1:0] csr_data_out
);

  localparam logic [2:0]  FNC_CSRRW = 3'b001;
  localparam int unsigned CW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              req_we_q;
  logic [AWIDTH-1:0] req_addr_q;
  logic [DWIDTH-1:0] req_wdata_q;
  logic              resp_valid_q;
  logic [DWIDTH-1:0] resp_data_q;
  logic              pipe_act;
  logic              accept;
  logic              host_issue;

  assign pipe_act        = pipe_csr_we | pipe_csr_rd;
  assign host_resp_valid = resp_valid_q;
  assign host_resp_data  = resp_data_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    accept         = 1'b0;
    host_issue     = 1'b0;
    pipe_stall     = 1'b0;
    host_req_ready = (state_q == IDLE);
    csr_we         = pipe_csr_we;
    csr_rd         = pipe_csr_rd;
    csr_addr       = pipe_addr;
    csr_func       = pipe_func;
    csr_data_in    = pipe_wdata;

    unique case (state_q)
      IDLE: begin
        if (host_req_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // At the limit the host takes the port even if the pipeline wants it; the counter never passes LIMIT.
        if (!pipe_act || (count_q == LIMIT)) begin
          host_issue = 1'b1;
          pipe_stall = pipe_act;
          count_d    = '0;
          state_d    = CAPTURE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        if (host_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (host_issue) begin
      csr_we      = req_we_q;
      csr_rd      = ~req_we_q;
      csr_addr    = req_addr_q;
      csr_func    = FNC_CSRRW;
      csr_data_in = req_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (accept) begin
      req_we_q    <= host_we;
      req_addr_q  <= host_addr;
      req_wdata_q <= host_wdata;
    end
  end

  // csr_data_out is valid the cycle after the read issues, which is the CAPTURE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else if (state_q == CAPTURE) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= req_we_q ? '0 : csr_data_out;
    end else if ((state_q == RESP) && host_resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/csr_access_arbiter.md
Name: csr_access_arbiter

Overview:
Shares the EX-stage CSR file between two requesters: the pipeline's CSR instructions and a host debug port, such as a UART monitor.
- The pipeline has priority by default.
- A host request is latched, then issued when the pipeline leaves the CSR port idle.
- A starvation counter forces a one-cycle pipeline stall so the host always completes.
- Sits between the EX-stage control signals and the CSR instance.

Parameters:
DWIDTH, 32, CSR data width
AWIDTH, 12, CSR address width
STARVE_LIMIT, 8, host-wait cycles tolerated before pipeline is stalled (0 = host always wins at issue)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
pipe_csr_we  input  1  pipeline CSR write request
pipe_csr_rd  input  1  pipeline CSR read request
pipe_addr  input  AWIDTH  pipeline CSR address
pipe_func  input  3  pipeline CSR funct3
pipe_wdata  input  DWIDTH  pipeline CSR write data
pipe_stall  output  1  pipeline must hold its CSR instruction this cycle
host_req_valid  input  1  host request valid
host_req_ready  output  1  arbiter can accept a host request
host_we  input  1  1 = write, 0 = read
host_addr  input  AWIDTH  host CSR address
host_wdata  input  DWIDTH  host write data
host_resp_valid  output  1  response available
host_resp_ready  input  1  host consumes response
host_resp_data  output  DWIDTH  read data (0 for writes)
csr_we  output  1  to CSR we
csr_rd  output  1  to CSR rd
csr_addr  output  AWIDTH  to CSR addr
csr_func  output  3  to CSR func
csr_data_in  output  DWIDTH  to CSR data_in
csr_data_out  input  DWIDTH  from CSR; valid the cycle after rd is issued

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, starve counter 0, request registers 0; host_resp_valid 0, host_resp_data 0, pipe_stall 0, host_req_ready 1.
- Pipeline activity: pipe_act = pipe_csr_we | pipe_csr_rd.

States:
- IDLE: host_req_ready=1. On host_req_valid, latch we/addr/wdata and go to ISSUE. Acceptance never affects the CSR port in the same cycle.
- ISSUE: host_req_ready=0.
  - If pipe_act=0, issue the host access and go to CAPTURE.
  - If pipe_act=1 and count<STARVE_LIMIT, the pipeline owns the port and count increments.
  - If pipe_act=1 and count==STARVE_LIMIT, pipe_stall=1 (combinational, this cycle only), the host access is issued and the FSM goes to CAPTURE.
  - count clears on issue.
- CAPTURE: register host_resp_data = csr_data_out for reads, 0 for writes; set host_resp_valid=1; go to RESP.
- RESP: hold host_resp_valid/host_resp_data stable until host_resp_ready=1. On that cycle clear valid and return to IDLE.
  - No new host request is accepted until the following cycle.
  - Only one host transaction is outstanding.

Host issue drive:
- Read: csr_rd=1, csr_we=0, csr_func=FNC_CSRRW.
- Write: csr_we=1, csr_rd=0, csr_func=FNC_CSRRW, csr_data_in=latched wdata.
- csr_addr = latched addr in both cases.

Other cycles:
- csr_* = pipe_* pass-through; host never blocks the pipeline outside the stall cycle.
- pipe_stall=0 in every state except the forced-issue case above.

Boundaries and width rules:
- STARVE_LIMIT=0: the host issues in the first ISSUE cycle, stalling the pipeline if pipe_act=1.
- count width: clog2(STARVE_LIMIT+1), minimum 1; it saturates at STARVE_LIMIT and never wraps.
- pipe_act deasserts while waiting: the host issues next ISSUE cycle without stall.
- Reset mid-transaction: the transaction is dropped with no CSR write after reset.
  - A write already issued before reset stands.
  - host_resp_valid goes 0 immediately.
- host_req_valid is sampled only in IDLE; request fields may change after acceptance with no effect.

Test Plan:
- Reset: assert rst_n=0 mid-RESP → host_resp_valid=0 asynchronously, pipe_stall=0, host_req_ready=1 after release.
- Idle-pipeline host read: CSR 0x51E holds 0x0000_00AB; host read at T → csr_rd=1, addr=0x51E at T+1; host_resp_valid=1, data=0xAB at T+3; holds until host_resp_ready.
- Pipeline priority: pipe_act=1 for 3 cycles during ISSUE, STARVE_LIMIT=8 → csr_* follow pipe_* for those 3 cycles, no stall; host write 0x1234 to 0x51E issues on the 4th cycle; response data=0.
- Starvation: pipe_act held 1 continuously, STARVE_LIMIT=8 → exactly 8 pipeline-owned ISSUE cycles, then one cycle with pipe_stall=1 and csr driven by host; pipe_stall=0 afterwards.
- STARVE_LIMIT=0 with pipe_act=1 → pipe_stall=1 in first ISSUE cycle, host issued that cycle.
- Response backpressure: host_resp_ready low for 5 cycles → resp_valid/data stable; host_req_valid held 1 → host_req_ready=0 until the cycle after consumption.
